// File: rtl/q_timing_queue.sv
// Timing/issue queue: replays decoder-pushed WAIT/EVENT entries onto a cycle-accurate
// timeline, turning EVENTs into one-cycle strobes on masked quantum channels.
module q_timing_lane #(
  parameter int OP_W  = 4,
  parameter int ARG_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             strobe,
  input  logic [OP_W-1:0]  op,
  input  logic [ARG_W-1:0] arg,
  output logic             out_valid,
  output logic [OP_W-1:0]  out_op,
  output logic [ARG_W-1:0] out_arg
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_arg   <= '0;
    end else begin
      out_valid <= strobe;
      if (strobe) begin
        out_op  <= op;
        out_arg <= arg;
      end
    end
  end
endmodule

module q_timing_queue #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8,
  parameter int TIME_W = 20,
  parameter int OP_W   = 4,
  parameter int ARG_W  = 8,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_kind,
  input  logic [TIME_W-1:0]       in_wait,
  input  logic [NUM_CH-1:0]       in_ch_mask,
  input  logic [OP_W-1:0]         in_op,
  input  logic [ARG_W-1:0]        in_arg,
  input  logic                    run,
  input  logic                    flush,
  output logic [NUM_CH-1:0]       out_valid,
  output logic [NUM_CH*OP_W-1:0]  out_op,
  output logic [NUM_CH*ARG_W-1:0] out_arg,
  output logic [CNT_W-1:0]        count,
  output logic [TIME_W-1:0]       timeline,
  output logic                    idle
);
  typedef struct packed {
    logic              kind;
    logic [TIME_W-1:0] wait_n;
    logic [NUM_CH-1:0] mask;
    logic [OP_W-1:0]   op;
    logic [ARG_W-1:0]  arg;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  state_t            state;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [TIME_W-1:0] wait_cnt;
  logic              empty, full, push, pop, fire;

  assign head     = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = !flush && run && (state == S_IDLE) && !empty;
  assign fire     = pop && head.kind;
  assign idle     = (state == S_IDLE) && empty && (out_valid == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{kind: in_kind, wait_n: in_wait, mask: in_ch_mask, op: in_op, arg: in_arg};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= S_IDLE;
      wait_cnt <= '0;
      timeline <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= S_IDLE;
      wait_cnt <= '0;
      timeline <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      if (run) timeline <= timeline + TIME_W'(1);
      // The pop cycle is the first slot of a WAIT; wait_cnt holds the WAIT-state
      // slots left after the next one, so WAIT 0/1 never leave IDLE.
      case (state)
        S_IDLE: if (pop && !head.kind && head.wait_n > TIME_W'(1)) begin
          wait_cnt <= head.wait_n - TIME_W'(2);
          state    <= S_WAIT;
        end
        S_WAIT: if (run) begin
          if (wait_cnt == '0) state <= S_IDLE;
          else                wait_cnt <= wait_cnt - TIME_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    q_timing_lane #(.OP_W(OP_W), .ARG_W(ARG_W)) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .strobe    (fire && head.mask[c]),
      .op        (head.op),
      .arg       (head.arg),
      .out_valid (out_valid[c]),
      .out_op    (out_op[c*OP_W +: OP_W]),
      .out_arg   (out_arg[c*ARG_W +: ARG_W])
    );
  end
endmodule

// File: tb/tb_q_timing_queue.sv
// Directed bench for q_timing_queue: strobe timing, WAIT spacing, backpressure, freeze, flush, reset.
module tb_q_timing_queue;
  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, in_kind, run, flush, idle;
  logic [19:0] in_wait, timeline;
  logic [3:0]  in_ch_mask, in_op, out_valid, count;
  logic [7:0]  in_arg;
  logic [15:0] out_op;
  logic [31:0] out_arg;

  int nchk = 0, nerr = 0, cyc = 0;
  int scnt [4] = '{default: 0};
  int slast[4] = '{default: 0};
  int stl  [4] = '{default: 0};
  int push_cyc, base, n0, n1;

  q_timing_queue dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_wait(in_wait), .in_ch_mask(in_ch_mask), .in_op(in_op), .in_arg(in_arg), .run(run),
    .flush(flush), .out_valid(out_valid), .out_op(out_op), .out_arg(out_arg), .count(count),
    .timeline(timeline), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: per-channel strobe count, last strobe cycle and timeline at that strobe
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++)
      if (out_valid[c]) begin
        scnt[c]  <= scnt[c] + 1;
        slast[c] <= cyc;
        stl[c]   <= int'(timeline);
      end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic k, input logic [19:0] w, input logic [3:0] m,
                      input logic [3:0] op, input logic [7:0] arg);
    @(negedge clk);
    in_valid = 1'b1; in_kind = k; in_wait = w; in_ch_mask = m; in_op = op; in_arg = arg;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push_cyc = cyc;
  endtask

  task automatic spacing(input logic [19:0] w, input int exp);
    @(negedge clk); run = 1'b0;
    push(1'b1, 20'd0, 4'b0001, 4'd1, 8'h11);
    push(1'b0, w,     4'b0000, 4'd0, 8'h00);
    push(1'b1, 20'd0, 4'b0010, 4'd2, 8'h22);
    @(negedge clk); run = 1'b1;
    repeat (15) @(negedge clk);
    chk($sformatf("spacing_wait%0d", w), 64'(slast[1] - slast[0]), 64'(exp));
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_kind = 1'b0; in_wait = '0; in_ch_mask = '0;
    in_op = '0; in_arg = '0; run = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // T1 reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_valid",    64'(out_valid), 64'd0);
    chk("rst_timeline", 64'(timeline), 64'd0);
    chk("rst_idle",     64'(idle),     64'd1);

    // T2 single masked EVENT with run held high
    run = 1'b1;
    push(1'b1, 20'd0, 4'b0101, 4'd3, 8'h2A);
    repeat (3) @(negedge clk);
    chk("t2_cnt_ch0", 64'(scnt[0]), 64'd1);
    chk("t2_cnt_ch2", 64'(scnt[2]), 64'd1);
    chk("t2_cnt_ch13", 64'(scnt[1] + scnt[3]), 64'd0);
    chk("t2_latency", 64'(slast[0] - push_cyc), 64'd1);
    chk("t2_out_op",  64'(out_op),  64'h0303);
    chk("t2_out_arg", 64'(out_arg), 64'h002A_002A);

    // T3 WAIT spacing
    spacing(20'd5, 6);
    spacing(20'd0, 2);
    spacing(20'd1, 2);

    // T4 fill to full while frozen, then drain
    @(negedge clk); run = 1'b0;
    for (int i = 0; i < 8; i++) push(1'b1, 20'd0, 4'b1000, 4'(i), 8'(i));
    @(negedge clk);
    chk("t4_count_full", 64'(count),    64'd8);
    chk("t4_ready_full", 64'(in_ready), 64'd0);
    push(1'b1, 20'd0, 4'b1000, 4'd8, 8'd8);
    @(negedge clk);
    chk("t4_count_9th", 64'(count), 64'd8);
    n0 = scnt[3]; base = cyc; run = 1'b1;
    repeat (12) @(negedge clk);
    chk("t4_drained",   64'(scnt[3] - n0), 64'd8);
    chk("t4_last_cyc",  64'(slast[3] - base), 64'd8);
    chk("t4_last_op",   64'(out_op[15:12]), 64'd7);
    chk("t4_count_end", 64'(count), 64'd0);
    chk("t4_idle_end",  64'(idle),  64'd1);

    // T5 freeze for 3 cycles in the middle of WAIT 10
    run = 1'b0;
    push(1'b1, 20'd0,  4'b0001, 4'd4, 8'h44);
    push(1'b0, 20'd10, 4'b0000, 4'd0, 8'h00);
    push(1'b1, 20'd0,  4'b0010, 4'd5, 8'h55);
    @(negedge clk); run = 1'b1;
    repeat (4) @(negedge clk); run = 1'b0;
    repeat (3) @(negedge clk); run = 1'b1;
    repeat (25) @(negedge clk);
    chk("t5_spacing",  64'(slast[1] - slast[0]), 64'd14);
    chk("t5_timeline", 64'(stl[1] - stl[0]),     64'd11);

    // T6 flush during WAIT 100 with 3 entries queued
    run = 1'b0;
    push(1'b0, 20'd100, 4'b0000, 4'd0, 8'h00);
    for (int i = 0; i < 3; i++) push(1'b1, 20'd0, 4'b0001, 4'd6, 8'h66);
    @(negedge clk); run = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_count_pre", 64'(count), 64'd3);
    n0 = scnt[0];
    flush = 1'b1;
    #1;
    chk("t6_ready_flush", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("t6_count",    64'(count),    64'd0);
    chk("t6_idle",     64'(idle),     64'd1);
    chk("t6_timeline", 64'(timeline), 64'd0);
    flush = 1'b0;
    repeat (110) @(negedge clk);
    chk("t6_no_strobe", 64'(scnt[0] - n0), 64'd0);
    chk("t6_op_hold",   64'(out_op[3:0]), 64'd4);

    // Async reset mid-WAIT, with a loaded channel slice
    run = 1'b0;
    push(1'b1, 20'd0,  4'b0100, 4'd9, 8'h99);
    push(1'b0, 20'd50, 4'b0000, 4'd0, 8'h00);
    push(1'b1, 20'd0,  4'b0010, 4'd7, 8'h77);
    @(negedge clk); run = 1'b1;
    repeat (6) @(negedge clk);
    chk("ar_pre_op", 64'(out_op[11:8]), 64'd9);
    n1 = scnt[1];
    #2 reset_n = 1'b0;
    #1;
    chk("ar_count",    64'(count),     64'd0);
    chk("ar_timeline", 64'(timeline),  64'd0);
    chk("ar_op",       64'(out_op),    64'd0);
    chk("ar_arg",      64'(out_arg),   64'd0);
    chk("ar_valid",    64'(out_valid), 64'd0);
    chk("ar_idle",     64'(idle),      64'd1);
    @(negedge clk); reset_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("ar_no_strobe", 64'(scnt[1] - n1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
